// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: default widths and shared types for the writeback arbiter.
package regfile_pkg;
  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_REQ = 3;
  typedef logic [ADDR_WIDTH-1:0] reg_idx_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;
  typedef logic [$clog2(NUM_REQ)-1:0] req_idx_t;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first valid requester at or after the pointer.
module rr_arbiter import regfile_pkg::*; #(
  parameter int N = NUM_REQ,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_valid,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx
);
  // Scan from the farthest offset down so the nearest valid requester is written last.
  always_comb begin
    o_grant = '0;
    o_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_valid[(int'(i_ptr) + k) % N]) begin
        o_grant = '0;
        o_grant[(int'(i_ptr) + k) % N] = 1'b1;
        o_idx = IW'((int'(i_ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin sharing of the register-file write port plus a busy scoreboard.
// Define WB_BYPASS_EN to add write-port forwarding outputs for the two source checks.
module regfile_wb_arbiter import regfile_pkg::*; #(
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int NUM_REQ = regfile_pkg::NUM_REQ,
  localparam int IW = $clog2(NUM_REQ),
  localparam int NREG = 2 ** ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic                         rf_we,
  output logic [ADDR_WIDTH-1:0]        rf_waddr,
  output logic [DATA_WIDTH-1:0]        rf_wdata,
  input  logic                         rsv_valid,
  input  logic [ADDR_WIDTH-1:0]        rsv_addr,
  output logic                         rsv_ready,
  input  logic [ADDR_WIDTH-1:0]        chk_addr1,
  input  logic [ADDR_WIDTH-1:0]        chk_addr2,
  output logic                         chk_busy1,
  output logic                         chk_busy2
`ifdef WB_BYPASS_EN
  ,
  output logic                         fwd_valid1,
  output logic                         fwd_valid2,
  output logic [DATA_WIDTH-1:0]        fwd_data1,
  output logic [DATA_WIDTH-1:0]        fwd_data2
`endif
);
  logic [IW-1:0] r_ptr;
  logic r_we;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [NREG-1:0] r_busy;
  logic [NUM_REQ-1:0] w_grant;
  logic [IW-1:0] w_idx;
  logic w_hs;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [NREG-1:0] w_clr, w_set;
  logic w_fwd1, w_fwd2;
  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .i_valid(req_valid),
    .i_ptr  (r_ptr),
    .o_grant(w_grant),
    .o_idx  (w_idx)
  );
  assign req_ready = w_grant;
  assign w_hs = |w_grant;
  assign w_addr = req_addr[int'(w_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_data = req_data[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH];
  // A register whose write is on the port this cycle may be re-reserved immediately.
  assign rsv_ready = (rsv_addr == '0) | ~r_busy[rsv_addr] | (r_we & (r_waddr == rsv_addr));
  assign w_clr = r_we ? (NREG'(1) << r_waddr) : '0;
  assign w_set = (rsv_valid & rsv_ready & (rsv_addr != '0)) ? (NREG'(1) << rsv_addr) : '0;
`ifdef WB_BYPASS_EN
  assign w_fwd1 = r_we & (r_waddr == chk_addr1) & (chk_addr1 != '0);
  assign w_fwd2 = r_we & (r_waddr == chk_addr2) & (chk_addr2 != '0);
  assign fwd_valid1 = w_fwd1;
  assign fwd_valid2 = w_fwd2;
  assign fwd_data1 = r_wdata;
  assign fwd_data2 = r_wdata;
`else
  assign w_fwd1 = 1'b0;
  assign w_fwd2 = 1'b0;
`endif
  assign chk_busy1 = r_busy[chk_addr1] & ~w_fwd1;
  assign chk_busy2 = r_busy[chk_addr2] & ~w_fwd2;
  assign rf_we = r_we;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
      r_we <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_busy <= '0;
    end else begin
      r_we <= w_hs & (w_addr != '0);
      r_busy <= (r_busy & ~w_clr) | w_set;
      if (w_hs) begin
        r_ptr <= (int'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + 1'b1;
        r_waddr <= w_addr;
        r_wdata <= w_data;
      end
    end
  end
`ifndef SYNTHESIS
  always @(posedge clk)
    if (!rst && r_we) assert (r_busy[r_waddr]) else $warning("writeback to unreserved register x%0d", r_waddr);
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and random stimulus checked against a queue-free behavioural model.
module tb_regfile_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 3;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0] req_ready;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic rsv_valid = 0;
  logic [AW-1:0] rsv_addr = '0;
  logic rsv_ready;
  logic [AW-1:0] chk_addr1 = '0;
  logic [AW-1:0] chk_addr2 = '0;
  logic chk_busy1, chk_busy2;
`ifdef WB_BYPASS_EN
  logic fwd_valid1, fwd_valid2;
  logic [DW-1:0] fwd_data1, fwd_data2;
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_data(req_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .chk_busy1(chk_busy1), .chk_busy2(chk_busy2)
`ifdef WB_BYPASS_EN
    , .fwd_valid1(fwd_valid1), .fwd_valid2(fwd_valid2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
`endif
  );
  int checks = 0;
  int errors = 0;
  int ptr;
  bit busy [32];
  bit m_we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic mreset();
    ptr = 0;
    foreach (busy[i]) busy[i] = 0;
    m_we = 0;
    m_waddr = '0;
    m_wdata = '0;
  endtask
  function automatic int pick();
    for (int k = 0; k < NR; k++) if (req_valid[(ptr + k) % NR]) return (ptr + k) % NR;
    return -1;
  endfunction
  function automatic bit fwd(logic [AW-1:0] a);
    return BYP && m_we && m_waddr == a && a != 0;
  endfunction
  task automatic set_req(int i, logic v, logic [AW-1:0] a, logic [DW-1:0] d);
    req_valid[i] = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask
  task automatic idle();
    req_valid = '0;
    rsv_valid = 0;
  endtask
  task automatic cyc();
    int g;
    bit ok;
    logic [AW-1:0] a;
    #1;
    g = pick();
    chk("req_ready", req_ready, g < 0 ? 64'd0 : 64'd1 << g);
    ok = rsv_addr == 0 || !busy[rsv_addr] || (m_we && m_waddr == rsv_addr);
    chk("rsv_ready", rsv_ready, ok);
    chk("chk_busy1", chk_busy1, busy[chk_addr1] && !fwd(chk_addr1));
    chk("chk_busy2", chk_busy2, busy[chk_addr2] && !fwd(chk_addr2));
`ifdef WB_BYPASS_EN
    chk("fwd_valid1", fwd_valid1, fwd(chk_addr1));
    chk("fwd_valid2", fwd_valid2, fwd(chk_addr2));
    if (fwd(chk_addr1)) chk("fwd_data1", fwd_data1, m_wdata);
    if (fwd(chk_addr2)) chk("fwd_data2", fwd_data2, m_wdata);
`endif
    @(posedge clk);
    if (m_we) busy[m_waddr] = 0;
    if (rsv_valid && ok && rsv_addr != 0) busy[rsv_addr] = 1;
    if (g >= 0) begin
      a = req_addr[g*AW +: AW];
      ptr = (g + 1) % NR;
      m_we = a != 0;
      m_waddr = a;
      m_wdata = req_data[g*DW +: DW];
    end else m_we = 0;
    #1;
    chk("rf_we", rf_we, m_we);
    chk("rf_waddr", rf_waddr, m_waddr);
    chk("rf_wdata", rf_wdata, m_wdata);
  endtask
  initial begin
    mreset();
    #12;
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_busy", chk_busy1, 0);
    rst = 0;
    for (int i = 0; i < NR; i++) set_req(i, 1, AW'(i + 1), $urandom);
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("rr_we", rf_we, 1);
      chk("rr_waddr", rf_waddr, (k % 3) + 1);
    end
    idle();
    set_req(0, 1, 5'd3, 32'hDEAD_BEEF);
    #1 chk("sw_ready", req_ready, 3'b001);
    cyc();
    chk("sw_we", rf_we, 1);
    chk("sw_waddr", rf_waddr, 3);
    chk("sw_wdata", rf_wdata, 32'hDEAD_BEEF);
    idle();
    cyc();
    chk("sw_we_off", rf_we, 0);
    set_req(1, 1, 5'd0, 32'h1234);
    rsv_valid = 1;
    rsv_addr = 0;
    chk_addr1 = 0;
    #1;
    chk("x0_ready", req_ready, 3'b010);
    chk("x0_rsv", rsv_ready, 1);
    cyc();
    chk("x0_we", rf_we, 0);
    chk("x0_busy", chk_busy1, 0);
    idle();
    rsv_valid = 1;
    rsv_addr = 7;
    chk_addr1 = 7;
    cyc();
    chk("sb_busy7", chk_busy1, 1);
    #1 chk("sb_rsv_again", rsv_ready, 0);
    cyc();
    rsv_valid = 0;
    set_req(2, 1, 5'd7, $urandom);
    cyc();
    idle();
    rsv_valid = 1;
    rsv_addr = 7;
    #1 chk("sb_rsv_on_we", rsv_ready, 1);
    cyc();
    idle();
    #1 chk("sb_set_wins", chk_busy1, 1);
    set_req(0, 1, 5'd7, $urandom);
    cyc();
    idle();
    cyc();
    chk("sb_cleared", chk_busy1, 0);
    rsv_valid = 1;
    rsv_addr = 9;
    cyc();
    idle();
    set_req(0, 1, 5'd9, 32'h55);
    cyc();
    idle();
    chk_addr2 = 9;
    #1;
`ifdef WB_BYPASS_EN
    chk("byp_valid2", fwd_valid2, 1);
    chk("byp_data2", fwd_data2, 32'h55);
    chk("byp_busy2", chk_busy2, 0);
`else
    chk("nobyp_busy2", chk_busy2, 1);
`endif
    cyc();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NR; i++) set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom);
      rsv_valid = 1'($urandom_range(0, 1));
      rsv_addr = AW'($urandom_range(0, 7));
      chk_addr1 = AW'($urandom_range(0, 7));
      chk_addr2 = AW'($urandom_range(0, 7));
      cyc();
    end
    idle();
    rsv_valid = 1;
    rsv_addr = 5;
    cyc();
    idle();
    set_req(0, 1, 5'd5, $urandom);
    chk_addr1 = 5;
    cyc();
    idle();
    chk("mid_we", rf_we, 1);
    rst = 1;
    #1;
    chk("mid_rst_we", rf_we, 0);
    chk("mid_rst_busy5", chk_busy1, 0);
    mreset();
    rst = 0;
    req_valid = 3'b111;
    #1 chk("mid_rst_grant0", req_ready, 3'b001);
    cyc();
    idle();
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
